imem_fetch_responder: RTL and testbench

IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

---
 rtl/imem_fetch_responder.sv | 88 ++++++++
 tb/tb_imem_fetch_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction memory with a valid/ready fetch port and a 2-entry ordered response buffer.
// Faulting fetches (misaligned or beyond the loaded depth) return a zero word with resp_fault set.
module imem_fetch_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_instr,
    output logic          resp_fault,
    input  logic          flush,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data
);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] slot_instr [2];
    logic        slot_fault [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        accept;
    logic        pop;
    logic        addr_fault;
    logic [31:0] read_word;

    assign pop        = resp_valid && resp_ready;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (count != 2'd0);
    assign resp_instr = resp_valid ? slot_instr[rd_ptr] : 32'h0000_0000;
    assign resp_fault = resp_valid ? slot_fault[rd_ptr] : 1'b0;

    assign addr_fault = (req_addr[1:0] != 2'b00) ||
                        ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign read_word  = mem[req_addr[AW+1:2]];

    // A full buffer can still take a request when the head leaves in the same cycle.
    always_comb begin
        req_ready = 1'b0;
        if (reset && !flush) begin
            req_ready = (count != 2'd2) || pop;
        end
    end

    // Memory holds its program across reset; the read port sees the pre-write word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // The memory read is captured at acceptance, so the word is in flight for exactly one
    // cycle and is presented the cycle after acceptance whenever the buffer was empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slot_instr[i] <= 32'h0000_0000;
                slot_fault[i] <= 1'b0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (accept) begin
                slot_instr[wr_ptr] <= addr_fault ? 32'h0000_0000 : read_word;
                slot_fault[wr_ptr] <= addr_fault;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, accept} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: expected responses are queued at acceptance
// and compared against the DUT head every cycle it presents a response.
module tb_imem_fetch_responder;

    localparam int DEPTH_WORDS = 64;
    localparam int AW          = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_instr;
    logic          resp_fault;
    logic          flush = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [31:0]   prog_data = '0;

    logic [32:0] sb [$];
    logic [31:0] model_mem [DEPTH_WORDS];
    int checks = 0;
    int failures = 0;
    int obs_pops = 0;

    imem_fetch_responder #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_fault(resp_fault),
        .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] model_fetch(input logic [31:0] addr);
        logic [29:0] widx;
        widx = addr[31:2];
        if (addr[1:0] != 2'b00 || {2'b00, widx} >= 32'(DEPTH_WORDS))
            return {1'b1, 32'h0000_0000};
        return {1'b0, model_mem[addr[AW+1:2]]};
    endfunction

    // One clock cycle: inputs are already driven just after a falling edge.
    task automatic cycle();
        logic exp_ready;
        logic sb_pop;
        #1;
        checks++;
        if (resp_valid !== (sb.size() != 0)) begin
            failures++;
            $display("[TB] FAIL resp_valid: got %b expected %b", resp_valid, sb.size() != 0);
        end
        if (resp_valid === 1'b1 && sb.size() != 0) begin
            checks++;
            if ({resp_fault, resp_instr} !== sb[0]) begin
                failures++;
                $display("[TB] FAIL resp_data: got fault=%b instr=%h expected fault=%b instr=%h",
                         resp_fault, resp_instr, sb[0][32], sb[0][31:0]);
            end
        end
        if (resp_valid === 1'b1 && resp_ready) obs_pops++;
        sb_pop    = resp_ready && sb.size() != 0;
        exp_ready = !flush && (sb.size() < 2 || sb_pop);
        checks++;
        if (req_ready !== exp_ready) begin
            failures++;
            $display("[TB] FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (sb_pop) void'(sb.pop_front());
            if (req_valid && exp_ready) sb.push_back(model_fetch(req_addr));
        end
        if (prog_we) model_mem[prog_addr] = prog_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; prog_we = 1'b0; flush = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_instr !== 32'h0 || resp_fault !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got v=%b i=%h f=%b r=%b expected all zero",
                     resp_valid, resp_instr, resp_fault, req_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: got %b expected 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        logic [31:0] words [6];
        logic [AW-1:0] idxs [6];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'hCAFE0063};
        idxs  = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd63};
        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = idxs[i]; prog_data = words[i];
            cycle();
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = obs_pops;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            cycle();
        end
        idle(2);
        checks++;
        if (obs_pops - start_pops != 4) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d responses expected 4", obs_pops - start_pops);
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd0; cycle();
        req_addr = 32'd4; cycle();
        req_addr = 32'd8; #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_stall: got req_ready=%b expected 0", req_ready);
        end
        cycle();
        resp_ready = 1'b1;
        cycle();
        idle(3);
    endtask

    task automatic test_fault();
        logic [31:0] addrs [5];
        addrs = '{32'd6, 32'd256, 32'd252, 32'h8000_0000, 32'd17};
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_addr = addrs[i];
            cycle();
        end
        idle(2);
    endtask

    task automatic test_flush();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd0; cycle();
        req_addr = 32'd4; cycle();
        flush = 1'b1; req_addr = 32'd12; cycle();
        flush = 1'b0; req_valid = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_empty: got resp_valid=%b expected 0", resp_valid);
        end
        cycle();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'd8; cycle();
        idle(2);
        // flush landing on the same edge as a pop
        req_valid = 1'b1; req_addr = 32'd12; cycle();
        req_valid = 1'b0; flush = 1'b1; cycle();
        idle(2);
    endtask

    task automatic test_write_collision();
        resp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'd4;
        prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'hDEADBEEF;
        cycle();
        prog_we = 1'b0;
        cycle();
        idle(2);
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'd0; cycle();
        req_addr = 32'd8; cycle();
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (resp_valid !== 1'b0 || resp_instr !== 32'h0 || resp_fault !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got v=%b i=%h f=%b r=%b expected all zero",
                     resp_valid, resp_instr, resp_fault, req_ready);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        resp_ready = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            cycle();
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_fault();
        test_flush();
        test_write_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
